// File: rtl/decode_stage.sv
// Registered RV32I decode stage with a 2-entry skid buffer on a valid/ready handshake.
// Optional macro DECODE_MULDIV_EN makes R-type funct7=0x01 legal and reports it on out_muldiv.
module decode_stage #(
   parameter int XLEN     = 32,
   parameter int PC_WIDTH = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                flush,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [31:0]         in_instr,
   input  logic [PC_WIDTH-1:0] in_pc,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [PC_WIDTH-1:0] out_pc,
   output logic [3:0]          out_op,
   output logic [XLEN-1:0]     out_imm,
   output logic [4:0]          out_rs1,
   output logic [4:0]          out_rs2,
   output logic                out_rs1_valid,
   output logic                out_rs2_valid,
   output logic [4:0]          out_rd,
   output logic                out_rd_valid,
   output logic [2:0]          out_funct3,
   output logic [6:0]          out_funct7,
   output logic                out_illegal,
   output logic                out_muldiv
);

   typedef enum logic [3:0] {
      OP_ALU_R = 4'd0, OP_ALU_I = 4'd1, OP_LOAD = 4'd2, OP_STORE = 4'd3,
      OP_BRANCH = 4'd4, OP_JAL = 4'd5, OP_JALR = 4'd6, OP_LUI = 4'd7,
      OP_AUIPC = 4'd8, OP_SYSTEM = 4'd9, OP_FENCE = 4'd10, OP_ILLEGAL = 4'd15
   } op_e;

   typedef struct packed {
      logic [PC_WIDTH-1:0] pc;
      logic [3:0]          op;
      logic [XLEN-1:0]     imm;
      logic [4:0]          rs1;
      logic [4:0]          rs2;
      logic                rs1_v;
      logic                rs2_v;
      logic [4:0]          rd;
      logic                rd_v;
      logic [2:0]          funct3;
      logic [6:0]          funct7;
      logic                illegal;
      logic                muldiv;
   } bundle_t;

   logic [6:0] opc;
   logic [2:0] f3;
   logic [6:0] f7;
   logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;

   assign opc    = in_instr[6:0];
   assign f3     = in_instr[14:12];
   assign f7     = in_instr[31:25];
   assign imm_i  = XLEN'($signed(in_instr[31:20]));
   assign imm_s  = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
   assign imm_b  = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0}));
   assign imm_u  = XLEN'($signed({in_instr[31:12], 12'b0}));
   assign imm_j  = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0}));
   assign imm_sh = XLEN'(in_instr[24:20]);

   bundle_t dec;
   logic    legal;

   always_comb begin
      dec        = '0;
      legal      = 1'b1;
      dec.pc     = in_pc;
      dec.rs1    = in_instr[19:15];
      dec.rs2    = in_instr[24:20];
      dec.rd     = in_instr[11:7];
      dec.funct3 = f3;
      case (opc)
         7'b0110011: begin
            dec.op = OP_ALU_R; dec.funct7 = f7;
            dec.rs1_v = 1'b1; dec.rs2_v = 1'b1; dec.rd_v = 1'b1;
            case (f7)
               7'h00:   legal = 1'b1;
               7'h20:   legal = (f3 == 3'd0) || (f3 == 3'd5);
`ifdef DECODE_MULDIV_EN
               7'h01:   dec.muldiv = 1'b1;
`endif
               default: legal = 1'b0;
            endcase
         end
         7'b0010011: begin
            dec.op = OP_ALU_I; dec.rs1_v = 1'b1; dec.rd_v = 1'b1;
            if (f3 == 3'd1 || f3 == 3'd5) begin
               dec.imm    = imm_sh;
               dec.funct7 = f7;
               legal      = (f7 == 7'h00) || (f7 == 7'h20 && f3 == 3'd5);
            end else begin
               dec.imm = imm_i;
            end
         end
         7'b0000011: begin
            dec.op = OP_LOAD; dec.imm = imm_i; dec.rs1_v = 1'b1; dec.rd_v = 1'b1;
            legal = !(f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
         end
         7'b0100011: begin
            dec.op = OP_STORE; dec.imm = imm_s; dec.rs1_v = 1'b1; dec.rs2_v = 1'b1;
            legal = (f3 < 3'd3);
         end
         7'b1100011: begin
            dec.op = OP_BRANCH; dec.imm = imm_b; dec.rs1_v = 1'b1; dec.rs2_v = 1'b1;
            legal = !(f3 == 3'd2 || f3 == 3'd3);
         end
         7'b1101111: begin dec.op = OP_JAL; dec.imm = imm_j; dec.rd_v = 1'b1; end
         7'b1100111: begin
            dec.op = OP_JALR; dec.imm = imm_i; dec.rs1_v = 1'b1; dec.rd_v = 1'b1;
            legal = (f3 == 3'd0);
         end
         7'b0110111: begin dec.op = OP_LUI;    dec.imm = imm_u; dec.rd_v = 1'b1; end
         7'b0010111: begin dec.op = OP_AUIPC;  dec.imm = imm_u; dec.rd_v = 1'b1; end
         7'b1110011: begin dec.op = OP_SYSTEM; dec.imm = imm_i; end
         7'b0001111: begin dec.op = OP_FENCE;  dec.imm = imm_i; end
         default:    legal = 1'b0;
      endcase
      if (dec.rd == 5'd0) dec.rd_v = 1'b0;
      // Illegal bundles keep indices/funct fields for debug but claim no operands.
      if (!legal) begin
         dec.op      = OP_ILLEGAL;
         dec.illegal = 1'b1;
         dec.imm     = '0;
         dec.rs1_v   = 1'b0;
         dec.rs2_v   = 1'b0;
         dec.rd_v    = 1'b0;
         dec.muldiv  = 1'b0;
      end
   end

   bundle_t main_q, main_d, skid_q, skid_d;
   logic    main_v_q, main_v_d, skid_v_q, skid_v_d;
   logic    accept, pop;

   assign in_ready = !skid_v_q;
   assign accept   = in_valid && in_ready;
   assign pop      = main_v_q && out_ready;

   always_comb begin
      main_d   = main_q;
      main_v_d = main_v_q;
      skid_d   = skid_q;
      skid_v_d = skid_v_q;
      if (flush) begin
         main_v_d = 1'b0;
         skid_v_d = 1'b0;
      end else if (!main_v_q) begin
         if (accept) begin main_d = dec; main_v_d = 1'b1; end
      end else if (pop) begin
         // accept cannot coincide with a full skid because in_ready is low then
         if (skid_v_q) begin
            main_d   = skid_q;
            skid_v_d = 1'b0;
         end else if (accept) begin
            main_d = dec;
         end else begin
            main_v_d = 1'b0;
         end
      end else if (accept) begin
         skid_d   = dec;
         skid_v_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         main_q   <= '0;
         skid_q   <= '0;
         main_v_q <= 1'b0;
         skid_v_q <= 1'b0;
      end else begin
         main_q   <= main_d;
         skid_q   <= skid_d;
         main_v_q <= main_v_d;
         skid_v_q <= skid_v_d;
      end
   end

   assign out_valid     = main_v_q;
   assign out_pc        = main_q.pc;
   assign out_op        = main_q.op;
   assign out_imm       = main_q.imm;
   assign out_rs1       = main_q.rs1;
   assign out_rs2       = main_q.rs2;
   assign out_rs1_valid = main_q.rs1_v;
   assign out_rs2_valid = main_q.rs2_v;
   assign out_rd        = main_q.rd;
   assign out_rd_valid  = main_q.rd_v;
   assign out_funct3    = main_q.funct3;
   assign out_funct7    = main_q.funct7;
   assign out_illegal   = main_q.illegal;
   assign out_muldiv    = main_q.muldiv;

endmodule

// File: tb/tb_decode_stage.sv
// Testbench for decode_stage: directed decode vectors, backpressure, flush, reset
// and a randomized stream checked against a reference decoder through a scoreboard.
module tb_decode_stage;

   typedef struct packed {
      logic [31:0] pc;
      logic [3:0]  op;
      logic [31:0] imm;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic        rs1v;
      logic        rs2v;
      logic [4:0]  rd;
      logic        rdv;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic        ill;
      logic        md;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
   logic [31:0] in_instr, in_pc, out_pc, out_imm;
   logic [3:0]  out_op;
   logic [4:0]  out_rs1, out_rs2, out_rd;
   logic        out_rs1_valid, out_rs2_valid, out_rd_valid, out_illegal, out_muldiv;
   logic [2:0]  out_funct3;
   logic [6:0]  out_funct7;

   int total = 0;
   int bad   = 0;
   int pop_cnt = 0;
   exp_t sb[$];
   logic [31:0] seen[$];
   exp_t obs, prev, e_m;
   bit have_prev = 0;

   always #5 clk = ~clk;

   decode_stage #(.XLEN(32), .PC_WIDTH(32)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_op(out_op),
      .out_imm(out_imm), .out_rs1(out_rs1), .out_rs2(out_rs2),
      .out_rs1_valid(out_rs1_valid), .out_rs2_valid(out_rs2_valid),
      .out_rd(out_rd), .out_rd_valid(out_rd_valid), .out_funct3(out_funct3),
      .out_funct7(out_funct7), .out_illegal(out_illegal), .out_muldiv(out_muldiv)
   );

   assign obs = {out_pc, out_op, out_imm, out_rs1, out_rs2, out_rs1_valid, out_rs2_valid,
                 out_rd, out_rd_valid, out_funct3, out_funct7, out_illegal, out_muldiv};

   function automatic exp_t ref_decode(input logic [31:0] w, input logic [31:0] pc);
      exp_t e;
      bit   ok;
      e = '0; ok = 1;
      e.pc = pc; e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.rd = w[11:7]; e.f3 = w[14:12];
      case (w[6:0])
         7'h33: begin
            e.op = 0; e.f7 = w[31:25]; e.rs1v = 1; e.rs2v = 1; e.rdv = 1;
            if (w[31:25] == 7'h01) begin
`ifdef DECODE_MULDIV_EN
               e.md = 1;
`else
               ok = 0;
`endif
            end else if (w[31:25] == 7'h20) ok = (w[14:12] == 0) || (w[14:12] == 5);
            else ok = (w[31:25] == 7'h00);
         end
         7'h13: begin
            e.op = 1; e.rs1v = 1; e.rdv = 1;
            if (w[14:12] == 1 || w[14:12] == 5) begin
               e.f7 = w[31:25]; e.imm = {27'b0, w[24:20]};
               ok = (w[31:25] == 0) || (w[31:25] == 7'h20 && w[14:12] == 5);
            end else e.imm = {{20{w[31]}}, w[31:20]};
         end
         7'h03: begin
            e.op = 2; e.imm = {{20{w[31]}}, w[31:20]}; e.rs1v = 1; e.rdv = 1;
            ok = !(w[14:12] == 3 || w[14:12] == 6 || w[14:12] == 7);
         end
         7'h23: begin
            e.op = 3; e.imm = {{20{w[31]}}, w[31:25], w[11:7]}; e.rs1v = 1; e.rs2v = 1;
            ok = (w[14:12] < 3);
         end
         7'h63: begin
            e.op = 4; e.imm = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            e.rs1v = 1; e.rs2v = 1; ok = !(w[14:12] == 2 || w[14:12] == 3);
         end
         7'h6F: begin e.op = 5; e.imm = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0}; e.rdv = 1; end
         7'h67: begin e.op = 6; e.imm = {{20{w[31]}}, w[31:20]}; e.rs1v = 1; e.rdv = 1; ok = (w[14:12] == 0); end
         7'h37: begin e.op = 7; e.imm = {w[31:12], 12'b0}; e.rdv = 1; end
         7'h17: begin e.op = 8; e.imm = {w[31:12], 12'b0}; e.rdv = 1; end
         7'h73: begin e.op = 9;  e.imm = {{20{w[31]}}, w[31:20]}; end
         7'h0F: begin e.op = 10; e.imm = {{20{w[31]}}, w[31:20]}; end
         default: ok = 0;
      endcase
      if (e.rd == 0) e.rdv = 0;
      if (!ok) begin
         e.op = 15; e.ill = 1; e.imm = 0; e.rs1v = 0; e.rs2v = 0; e.rdv = 0; e.md = 0;
      end
      return e;
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [6:0]  opcs [12] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F,
                                 7'h67, 7'h37, 7'h17, 7'h73, 7'h0F, 7'h7B};
      logic [6:0]  f7s  [4]  = '{7'h00, 7'h20, 7'h01, 7'h55};
      logic [31:0] w;
      w = $urandom;
      w[6:0] = opcs[$urandom_range(0, 11)];
      if (w[6:0] == 7'h33 || w[6:0] == 7'h13) w[31:25] = f7s[$urandom_range(0, 3)];
      if ($urandom_range(0, 15) == 0) w[1:0] = 2'b01;
      return w;
   endfunction

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic push_one(input logic [31:0] w, input logic [31:0] pc);
      bit acc = 0;
      in_valid = 1; in_instr = w; in_pc = pc;
      for (int n = 0; n < 50; n++) begin
         acc = in_ready;
         step();
         if (acc) break;
      end
      in_valid = 0;
      if (!acc) begin
         total++; bad++;
         $display("FAIL push_timeout pc=%h in_ready stayed 0, required 1", pc);
      end
   endtask

   task automatic test_reset();
      rst = 1; step(); step();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
      total++; if (obs !== '0) begin bad++; $display("FAIL reset_bundle got=%h want=0", obs); end
      rst = 0; step();
   endtask

   task automatic test_decode_vec(input string nm, input logic [31:0] w, input logic [3:0] op,
                                  input logic [31:0] imm, input logic [4:0] rd, input logic rdv,
                                  input logic rs1v, input logic rs2v, input logic ill,
                                  input logic md, input logic [6:0] f7);
      out_ready = 1;
      push_one(w, 32'h100);
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL %s_latency out_valid=%b want=1", nm, out_valid); end
      total++; if (out_op !== op) begin bad++; $display("FAIL %s_op got=%0d want=%0d", nm, out_op, op); end
      total++; if (out_imm !== imm) begin bad++; $display("FAIL %s_imm got=%h want=%h", nm, out_imm, imm); end
      total++; if ({out_rd_valid, out_rs1_valid, out_rs2_valid} !== {rdv, rs1v, rs2v}) begin
         bad++; $display("FAIL %s_valids got=%b want=%b", nm, {out_rd_valid, out_rs1_valid, out_rs2_valid}, {rdv, rs1v, rs2v});
      end
      total++; if ({out_illegal, out_muldiv, out_funct7} !== {ill, md, f7}) begin
         bad++; $display("FAIL %s_flags got=%h want=%h", nm, {out_illegal, out_muldiv, out_funct7}, {ill, md, f7});
      end
      if (!ill) begin
         total++; if (out_rd !== rd) begin bad++; $display("FAIL %s_rd got=%0d want=%0d", nm, out_rd, rd); end
      end
      step();
   endtask

   task automatic test_backpressure();
      seen.delete();
      out_ready = 0;
      push_one(32'h00100093, 32'hA0);
      push_one(32'h00200113, 32'hB0);
      in_valid = 1; in_instr = 32'h00300193; in_pc = 32'hC0;
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready_low got=%b want=0", in_ready); end
      step();
      total++; if (in_ready !== 1'b0 || out_pc !== 32'hA0) begin
         bad++; $display("FAIL bp_hold in_ready=%b pc=%h want 0/a0", in_ready, out_pc);
      end
      out_ready = 1; step();
      total++; if (out_pc !== 32'hB0 || in_ready !== 1'b1) begin
         bad++; $display("FAIL bp_skid_move pc=%h in_ready=%b want b0/1", out_pc, in_ready);
      end
      step(); in_valid = 0;
      total++; if (out_valid !== 1'b1 || out_pc !== 32'hC0) begin
         bad++; $display("FAIL bp_third valid=%b pc=%h want 1/c0", out_valid, out_pc);
      end
      step();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_drained got=%b want=0", out_valid); end
      total++; if (seen.size() != 3 || seen[0] !== 32'hA0 || seen[1] !== 32'hB0 || seen[2] !== 32'hC0) begin
         bad++; $display("FAIL bp_order got %0d pops first=%h want a0,b0,c0", seen.size(), (seen.size() > 0) ? seen[0] : 32'h0);
      end
   endtask

   task automatic test_flush(input int held);
      out_ready = 0;
      for (int i = 0; i < held; i++) push_one(32'h00500293 + (i << 20), 32'hD00 + i * 4);
      flush = 1; in_valid = 1; in_instr = 32'h00700393; in_pc = 32'hDFC;
      step();
      flush = 0; in_valid = 0;
      total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         bad++; $display("FAIL flush%0d_state valid=%b in_ready=%b want 0/1", held, out_valid, in_ready);
      end
      out_ready = 1;
      for (int i = 0; i < 3; i++) begin
         step();
         total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush%0d_leak cyc=%0d pc=%h", held, i, out_pc); end
      end
   endtask

   task automatic test_rst_mid();
      out_ready = 0;
      push_one(32'h00100093, 32'hE0);
      push_one(32'hFFF00093, 32'hE4);
      rst = 1; step(); rst = 0;
      total++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || obs !== '0) begin
         bad++; $display("FAIL rst_mid valid=%b in_ready=%b bundle=%h want 0/1/0", out_valid, in_ready, obs);
      end
      out_ready = 1; step();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_leak got=%b want=0", out_valid); end
   endtask

   task automatic test_back_to_back();
      bit done = 0;
      int start = pop_cnt;
      fork
         begin
            for (int i = 0; i < 300; i++) begin
               if ($urandom_range(0, 3) == 0) step();
               push_one(rand_instr(), 32'h2000 + i * 4);
            end
            done = 1;
         end
         begin
            while (!done) begin out_ready = $urandom_range(0, 1); step(); end
         end
      join
      out_ready = 1;
      for (int i = 0; i < 20; i++) begin
         if (sb.size() == 0 && !out_valid) break;
         step();
      end
      total++; if (sb.size() != 0 || pop_cnt - start != 300) begin
         bad++; $display("FAIL b2b_drain left=%0d pops=%0d want 0/300", sb.size(), pop_cnt - start);
      end
   endtask

   initial begin
      rst = 1; flush = 0; in_valid = 0; in_instr = 0; in_pc = 0; out_ready = 0;
      fork
         forever begin
            @(negedge clk);
            if (rst || flush) begin
               sb.delete(); have_prev = 0;
            end else begin
               if (have_prev) begin
                  total++;
                  if (out_valid !== 1'b1 || obs !== prev) begin
                     bad++; $display("FAIL hold_stable got=%h want=%h", obs, prev);
                  end
               end
               if (out_valid && out_ready) begin
                  total++; pop_cnt++; seen.push_back(out_pc);
                  if (sb.size() == 0) begin
                     bad++; $display("FAIL unexpected_pop pc=%h queue empty", out_pc);
                  end else begin
                     e_m = sb.pop_front();
                     if (obs !== e_m) begin bad++; $display("FAIL decode_pop got=%h want=%h", obs, e_m); end
                  end
               end
               if (in_valid && in_ready) sb.push_back(ref_decode(in_instr, in_pc));
               have_prev = out_valid && !out_ready;
               prev = obs;
            end
         end
      join_none

      test_reset();
      test_decode_vec("addi", 32'hFFF00093, 4'd1, 32'hFFFFFFFF, 5'd1, 1, 1, 0, 0, 0, 7'h00);
      test_decode_vec("beq",  32'hFE000EE3, 4'd4, 32'hFFFFFFFC, 5'd29, 0, 1, 1, 0, 0, 7'h00);
      test_decode_vec("zero", 32'h00000000, 4'd15, 32'h0, 5'd0, 0, 0, 0, 1, 0, 7'h00);
      test_decode_vec("op7b", 32'h0000707B, 4'd15, 32'h0, 5'd0, 0, 0, 0, 1, 0, 7'h00);
`ifdef DECODE_MULDIV_EN
      test_decode_vec("mul",  32'h022081B3, 4'd0, 32'h0, 5'd3, 1, 1, 1, 0, 1, 7'h01);
`else
      test_decode_vec("mul",  32'h022081B3, 4'd15, 32'h0, 5'd3, 0, 0, 0, 1, 0, 7'h01);
`endif
      test_decode_vec("srai", 32'h4030D213, 4'd1, 32'h3, 5'd4, 1, 1, 0, 0, 0, 7'h20);
      test_decode_vec("lui",  32'h800002B7, 4'd7, 32'h80000000, 5'd5, 1, 0, 0, 0, 0, 7'h00);
      test_decode_vec("rd0",  32'h00100013, 4'd1, 32'h1, 5'd0, 0, 1, 0, 0, 0, 7'h00);
      test_backpressure();
      test_flush(2);
      test_flush(1);
      test_rst_mid();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
